uart_rx_frame_assembler: RTL

UART_RX_FRAME_ASSEMBLER -- requirements
Module: uart_rx_frame_assembler

---
 rtl/uart_rx_frame_assembler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_assembler.sv
// UART frame assembler: START_BYTE header, FRAME_LENGTH payload bytes,
// then a mod-256 checksum byte; holds a valid frame until acknowledged.
module uart_rx_frame_assembler #(
  parameter int          FRAME_LENGTH   = 784,
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [7:0]  START_BYTE     = 8'hAA,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done_tick,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [7:0]            rd_data,
  output logic                  frame_ready,
  input  logic                  frame_ack,
  output logic                  frame_error,
  output logic                  overrun,
  output logic [ADDR_WIDTH-1:0] byte_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX =
    ADDR_WIDTH'(FRAME_LENGTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_READY
  } state_t;

  state_t state_q, state_d;

  logic [7:0]            mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [7:0]            acc_q;
  logic [TW-1:0]         timer_q;
  logic                  err_q;
  logic                  ovr_q;
  logic [7:0]            rd_q;

  logic in_frame;
  logic timeout;
  logic start;
  logic store;
  logic bad;
  logic set_ovr;
  logic clr_ovr;

  // The timeout fires when the idle window closes with no tick pending.
  assign in_frame = (state_q == S_RECV) || (state_q == S_CHECK);
  assign timeout  = in_frame && !rx_done_tick && (timer_q == T_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_done_tick && rx_data == START_BYTE)
          state_d = S_RECV;
      end
      S_RECV: begin
        if (rx_done_tick && cnt_q == LAST_IDX)
          state_d = S_CHECK;
        else if (timeout)
          state_d = S_IDLE;
      end
      S_CHECK: begin
        if (rx_done_tick)
          state_d = (rx_data == acc_q) ? S_READY : S_IDLE;
        else if (timeout)
          state_d = S_IDLE;
      end
      S_READY: begin
        if (frame_ack)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    start   = 1'b0;
    store   = 1'b0;
    bad     = timeout;
    set_ovr = 1'b0;
    clr_ovr = 1'b0;
    unique case (state_q)
      S_IDLE:  start = rx_done_tick && (rx_data == START_BYTE);
      S_RECV:  store = rx_done_tick;
      S_CHECK: bad   = timeout || (rx_done_tick && rx_data != acc_q);
      S_READY: begin
        clr_ovr = frame_ack;
        set_ovr = rx_done_tick && !frame_ack;
      end
      default: ;
    endcase
  end

  // Counters, checksum, status flags and the registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      if (start) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (store) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_q + rx_data;
      end
      if (in_frame && !rx_done_tick && !timeout)
        timer_q <= timer_q + 1'b1;
      else
        timer_q <= '0;
      err_q <= bad;
      if (clr_ovr)      ovr_q <= 1'b0;
      else if (set_ovr) ovr_q <= 1'b1;
      rd_q <= mem[rd_addr];
    end
  end

  // Payload write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (store) mem[cnt_q] <= rx_data;
  end

  assign rd_data     = rd_q;
  assign frame_ready = (state_q == S_READY);
  assign frame_error = err_q;
  assign overrun     = ovr_q;
  assign byte_count  = cnt_q;

endmodule
